// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Function : MEM-stage load/store engine. Turns an effective address and a
//             load/store op into a word-aligned req/ack memory access. Also
//             extracts and extends load data, and flags misaligned, illegal
//             and bus-timeout exceptions.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int NBITS   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [3:0]       i_op,
   input  logic [NBITS-1:0] i_eff_addr,
   input  logic [NBITS-1:0] i_wdata,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [NBITS-1:0] o_mem_addr,
   output logic [3:0]       o_mem_be,
   output logic [NBITS-1:0] o_mem_wdata,
   input  logic             i_mem_ack,
   input  logic [NBITS-1:0] i_mem_rdata,
   output logic             o_done,
   output logic [NBITS-1:0] o_rdata,
   output logic [1:0]       o_exception
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b11;
   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b11;
   localparam logic [7:0] TIMEOUT_CNT  = 8'(TIMEOUT);

   state_t           state;
   logic [7:0]       timeout_cnt;
   logic [7:0]       cnt_next;

   // Attributes of the accepted request needed when the load data returns
   logic             lat_store;
   logic             lat_unsigned;
   logic [1:0]       lat_size;
   logic [1:0]       lat_addr_lo;

   // Request decode (evaluated on the incoming request)
   logic             req_illegal;
   logic             req_misaligned;
   logic [3:0]       req_be;
   logic [NBITS-1:0] req_wdata;

   // Load-data extraction (evaluated on the returning read word)
   logic [7:0]       lane_byte;
   logic [15:0]      lane_half;
   logic             ext_bit;
   logic [NBITS-1:0] load_ext;

   assign cnt_next = timeout_cnt + 8'd1;

   // Decode the incoming request: legality, alignment, byte enables, store lanes
   always_comb begin
      req_illegal    = (i_op[1:0] == 2'b10) || (i_op[3] && i_op[2]);
      req_misaligned = 1'b0;
      req_be         = 4'b0000;
      req_wdata      = i_wdata;
      case (i_op[1:0])
         SIZE_BYTE: begin
            req_be    = 4'b0001 << i_eff_addr[1:0];
            req_wdata = {4{i_wdata[7:0]}};
         end
         SIZE_HALF: begin
            req_misaligned = i_eff_addr[0];
            req_be         = i_eff_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata      = {2{i_wdata[15:0]}};
         end
         SIZE_WORD: begin
            req_misaligned = (i_eff_addr[1:0] != 2'b00);
            req_be         = 4'b1111;
         end
         default: begin
            req_be = 4'b0000;
         end
      endcase
   end

   // Select the addressed byte/half of the read word and sign/zero extend it
   always_comb begin
      lane_byte = i_mem_rdata[7:0];
      case (lat_addr_lo)
         2'd0:    lane_byte = i_mem_rdata[7:0];
         2'd1:    lane_byte = i_mem_rdata[15:8];
         2'd2:    lane_byte = i_mem_rdata[23:16];
         default: lane_byte = i_mem_rdata[31:24];
      endcase
      lane_half = lat_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      ext_bit   = 1'b0;
      load_ext  = i_mem_rdata;
      case (lat_size)
         SIZE_BYTE: begin
            ext_bit  = ~lat_unsigned & lane_byte[7];
            load_ext = {{24{ext_bit}}, lane_byte};
         end
         SIZE_HALF: begin
            ext_bit  = ~lat_unsigned & lane_half[15];
            load_ext = {{16{ext_bit}}, lane_half};
         end
         default: begin
            load_ext = i_mem_rdata;
         end
      endcase
   end

   // Control FSM with registered bus and response outputs
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state        <= IDLE;
         o_ready      <= 1'b1;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_be     <= 4'b0000;
         o_mem_wdata  <= '0;
         o_done       <= 1'b0;
         o_rdata      <= '0;
         o_exception  <= EXC_NONE;
         timeout_cnt  <= 8'd0;
         lat_store    <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_size     <= 2'b00;
         lat_addr_lo  <= 2'b00;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  lat_store    <= i_op[3];
                  lat_unsigned <= i_op[2];
                  lat_size     <= i_op[1:0];
                  lat_addr_lo  <= i_eff_addr[1:0];
                  o_ready      <= 1'b0;
                  timeout_cnt  <= 8'd0;
                  if (req_illegal) begin
                     state       <= RESP;
                     o_done      <= 1'b1;
                     o_rdata     <= '0;
                     o_exception <= EXC_ILLEGAL;
                  end else if (req_misaligned) begin
                     state       <= RESP;
                     o_done      <= 1'b1;
                     o_rdata     <= '0;
                     o_exception <= EXC_MISALIGN;
                  end else begin
                     state       <= ACCESS;
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= i_op[3];
                     o_mem_addr  <= {i_eff_addr[NBITS-1:2], 2'b00};
                     o_mem_be    <= req_be;
                     o_mem_wdata <= req_wdata;
                  end
               end
            end
            ACCESS: begin
               // An ack in the timeout cycle still counts as a normal completion
               if (i_mem_ack || (cnt_next == TIMEOUT_CNT)) begin
                  state       <= RESP;
                  o_done      <= 1'b1;
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= '0;
                  o_mem_be    <= 4'b0000;
                  o_mem_wdata <= '0;
                  timeout_cnt <= 8'd0;
                  if (i_mem_ack) begin
                     o_exception <= EXC_NONE;
                     o_rdata     <= lat_store ? '0 : load_ext;
                  end else begin
                     o_exception <= EXC_TIMEOUT;
                     o_rdata     <= '0;
                  end
               end else begin
                  timeout_cnt <= cnt_next;
               end
            end
            RESP: begin
               state       <= IDLE;
               o_ready     <= 1'b1;
               o_rdata     <= '0;
               o_exception <= EXC_NONE;
               timeout_cnt <= 8'd0;
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Function : Scoreboard bench for load_store_unit with a reference model of
//             byte-lane, extension and exception rules, directed plus
//             randomized operations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   localparam int TMO = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  exc;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic [3:0]  op = 4'd0;
   logic [31:0] eff_addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  exc;

   int tests = 0;
   int failed = 0;

   bus_t  bus_q[$];
   resp_t resp_q[$];
   int    len_q[$];

   always #5 clk = ~clk;

   load_store_unit #(.NBITS(32), .TIMEOUT(TMO)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_op        (op),
      .i_eff_addr  (eff_addr),
      .i_wdata     (wdata),
      .o_mem_req   (mem_req),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_be    (mem_be),
      .o_mem_wdata (mem_wdata),
      .i_mem_ack   (mem_ack),
      .i_mem_rdata (mem_rdata),
      .o_done      (done),
      .o_rdata     (rdata),
      .o_exception (exc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      failed++;
      $display("FAIL %s: event not expected / not seen at %0t", name, $time);
   endtask

   // Reference model: what the access should look like, from the op rules
   function automatic void ref_model(input logic [3:0] o, input logic [31:0] a32,
                                     input logic [31:0] wd, input logic [31:0] rd, input int k,
                                     output bit access, output bus_t b, output resp_t r,
                                     output int len);
      int nbytes;
      int a;
      bit illegal;
      logic [63:0] val;
      a = int'(a32[1:0]);
      case (o[1:0])
         2'b00:   nbytes = 1;
         2'b01:   nbytes = 2;
         2'b11:   nbytes = 4;
         default: nbytes = 0;
      endcase
      illegal = (nbytes == 0) || (o[3] && o[2]);
      access  = 1'b0;
      b       = '0;
      r       = '0;
      len     = 0;
      if (illegal) begin
         r.exc = 2'b11;
      end else if ((a % nbytes) != 0) begin
         r.exc = 2'b01;
      end else begin
         access  = 1'b1;
         b.addr  = a32 - 32'(a);
         b.be    = 4'(((1 << nbytes) - 1) << a);
         b.we    = o[3];
         if (nbytes == 1)      b.wdata = 32'(wd[7:0]) * 32'h01010101;
         else if (nbytes == 2) b.wdata = 32'(wd[15:0]) * 32'h00010001;
         else                  b.wdata = wd;
         if (k > TMO) begin
            len   = TMO;
            r.exc = 2'b10;
         end else begin
            len = k;
            if (!o[3]) begin
               val = 64'(rd >> (8 * a)) & ((64'd1 << (8 * nbytes)) - 64'd1);
               if (!o[2] && nbytes < 4 && val[8 * nbytes - 1])
                  val = val - (64'd1 << (8 * nbytes));
               r.rdata = val[31:0];
            end
         end
      end
   endfunction

   // Monitor: compares bus requests, request length and completions
   bus_t cur;
   bit   prev_req = 1'b0;
   bit   prev_done = 1'b0;
   int   req_len = 0;
   always @(negedge clk) begin
      if (mem_req && !prev_req) begin
         req_len = 1;
         if (bus_q.size() == 0) begin
            flag("unexpected_req");
            cur = '0;
         end else begin
            cur = bus_q.pop_front();
            check("bus_addr", mem_addr, cur.addr);
            check("bus_be", 32'(mem_be), 32'(cur.be));
            check("bus_we", 32'(mem_we), 32'(cur.we));
            check("bus_wdata", mem_wdata, cur.wdata);
         end
      end else if (mem_req) begin
         req_len++;
         check("bus_hold", {mem_addr[31:2], mem_be, mem_we, 1'b0},
               {cur.addr[31:2], cur.be, cur.we, 1'b0});
         check("bus_hold_wdata", mem_wdata, cur.wdata);
      end
      if (!mem_req && prev_req) begin
         if (len_q.size() == 0) flag("unexpected_req_end");
         else check("req_len", 32'(req_len), 32'(len_q.pop_front()));
      end
      if (done) begin
         if (prev_done) flag("done_not_single_cycle");
         if (resp_q.size() == 0) begin
            flag("unexpected_done");
         end else begin
            resp_t e;
            e = resp_q.pop_front();
            check("resp_rdata", rdata, e.rdata);
            check("resp_exc", 32'(exc), 32'(e.exc));
            check("resp_ready_low", 32'(ready), 32'd0);
         end
      end
      prev_req  = mem_req;
      prev_done = done;
   end

   task automatic do_op(input logic [3:0] o, input logic [31:0] a32, input logic [31:0] wd,
                        input logic [31:0] rd, input int k, input bit junk, input bit stray_ack);
      bit    access;
      bus_t  b;
      resp_t r;
      int    len;
      int    guard;
      guard = 0;
      while (!ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!ready) flag("ready_wait");
      ref_model(o, a32, wd, rd, k, access, b, r, len);
      if (access) begin
         bus_q.push_back(b);
         len_q.push_back(len);
      end
      resp_q.push_back(r);
      valid = 1'b1; op = o; eff_addr = a32; wdata = wd;
      @(posedge clk); #1;
      valid = 1'b0;
      if (junk) begin
         valid = 1'b1; op = 4'($urandom); eff_addr = $urandom; wdata = $urandom;
      end
      if (access && k <= TMO) begin
         repeat (k - 1) begin @(posedge clk); #1; end
         mem_ack = 1'b1; mem_rdata = rd;
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = $urandom;
      end
      guard = 0;
      while (!done && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!done) flag("done_wait");
      valid = 1'b0;
      if (stray_ack) begin
         mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_bus", {mem_addr[31:4], mem_be, 3'b0, mem_we}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_resp", {rdata[31:3], done, exc}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      do_op(4'b0011, 32'h00001000, 32'h0,        32'hDEADBEEF, 3, 1'b0, 1'b0); // LW
      do_op(4'b0000, 32'h00001003, 32'h0,        32'h80112233, 1, 1'b0, 1'b0); // LB
      do_op(4'b0100, 32'h00001003, 32'h0,        32'h80112233, 2, 1'b0, 1'b0); // LBU
      do_op(4'b1001, 32'h00002002, 32'h0000ABCD, 32'h12345678, 2, 1'b0, 1'b0); // SH
      do_op(4'b0011, 32'h00001002, 32'h0,        32'h0,        1, 1'b0, 1'b0); // misaligned LW
      do_op(4'b0010, 32'h00001000, 32'h0,        32'h0,        1, 1'b0, 1'b0); // illegal size
      do_op(4'b1100, 32'h00001000, 32'h0,        32'h0,        1, 1'b0, 1'b0); // illegal store
      do_op(4'b0001, 32'h00003002, 32'h0,        32'h8001_7FFF, 4, 1'b0, 1'b0); // LH upper, ack at limit
      do_op(4'b0011, 32'h00004000, 32'h0,        32'h0,        99, 1'b0, 1'b1); // timeout
      @(posedge clk); #1;
      check("ready_after_timeout", 32'(ready), 32'd1);

      // Reset asserted in the second ACCESS cycle
      begin
         bus_t b;
         b.addr = 32'h00005000; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0;
         bus_q.push_back(b);
         len_q.push_back(2);
         valid = 1'b1; op = 4'b0011; eff_addr = 32'h00005000; wdata = 32'h0;
         @(posedge clk); #1;
         valid = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b0;
         @(posedge clk); #1;
         check("midrst_req", 32'(mem_req), 32'd0);
         check("midrst_ready", 32'(ready), 32'd1);
         check("midrst_bus", {mem_addr[31:4], mem_be, 3'b0, mem_we}, 32'd0);
         check("midrst_resp", {rdata[31:3], done, exc}, 32'd0);
         rst_n = 1'b1;
         mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check("late_ack_ready", 32'(ready), 32'd1);
      end

      // Randomized operations
      for (int i = 0; i < 300; i++) begin
         logic [3:0]  ro;
         logic [31:0] ra;
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
         do_op(ro, ra, $urandom, $urandom, int'($urandom_range(1, TMO + 2)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      repeat (5) @(posedge clk);
      #1;
      check("queues_drained", 32'(bus_q.size() + resp_q.size() + len_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumer side of the address generator. Takes an effective address plus a load/store op and performs the data-memory access.
- Generates the word-aligned bus address and byte enables, and runs a req/ack handshake with data memory.
- Extracts and extends load data, and reports misalignment, illegal-op and bus-timeout exceptions.
- Sits in the MEM stage, between the AGU result and the data memory.

Parameters:
- NBITS, 32, data/address width (only 32 supported).
- TIMEOUT, 255, maximum number of cycles in ACCESS without i_mem_ack before a bus timeout is flagged; width of the counter is 8 bits.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  request strobe from pipeline; sampled only while o_ready=1.
- o_ready  out  1  unit is in IDLE and accepts a request.
- i_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size 00 byte / 01 half / 11 word.
- i_eff_addr  in  32  effective byte address.
- i_wdata  in  32  store data (right-justified).
- o_mem_req  out  1  memory request, held until ack or timeout.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  32  {eff_addr[31:2],2'b00}.
- o_mem_be  out  4  byte enables, little-endian lanes.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ack  in  1  memory completion, one cycle.
- i_mem_rdata  in  32  read word; valid with i_mem_ack.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load result; valid with o_done, 0 for stores and exceptions.
- o_exception  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal op; valid with o_done.

Behaviour:
- Reset (i_reset=0 at an edge), every output:
  - state IDLE, o_ready=1;
  - o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata = 0;
  - o_done=0, o_rdata=0, o_exception=00;
  - timeout counter=0.
  - Reset mid-access drops o_mem_req at that edge; no o_done is produced.
- FSM states IDLE, ACCESS, RESP.
- IDLE, when i_valid=1:
  - latch op and address;
  - illegal op (size=10, or store with [2]=1) -> RESP, exception 11;
  - misaligned (half with addr[0]=1; word with addr[1:0]!=00) -> RESP, exception 01;
  - in both exception cases o_mem_req is never asserted;
  - otherwise -> ACCESS, driving o_mem_req=1 together with address, we, be and wdata on the next cycle.
- ACCESS:
  - o_mem_req and all bus outputs held stable;
  - counter increments each cycle;
  - i_mem_ack=1 -> capture and extend rdata, deassert req, go to RESP, exception 00;
  - counter reaching TIMEOUT with no ack -> deassert req, go to RESP, exception 10;
  - ack in the same cycle as the timeout wins, giving a normal completion.
- RESP:
  - o_done=1 for exactly one cycle, o_ready=0;
  - next state IDLE; counter cleared.
- Latency:
  - request accepted at edge N; o_mem_req high from N+1;
  - ack sampled at edge M gives o_done high in cycle M+1;
  - minimum 3 cycles request-to-done;
  - exception paths give o_done the cycle after acceptance.
- Byte enables (a = addr[1:0]):
  - byte: 1<<a;
  - half: a=0 -> 0011, a=2 -> 1100;
  - word: 1111.
- Store data:
  - SB: wdata[7:0] replicated into all 4 lanes;
  - SH: wdata[15:0] replicated into both halves;
  - SW: wdata passed through unchanged.
- Load extraction:
  - byte = rdata[8a+7:8a];
  - half = rdata[16(a/2)+15:16(a/2)];
  - sign-extended unless op[2]=1, then zero-extended.
- i_mem_ack outside ACCESS is ignored. i_valid outside IDLE is ignored.

Test Plan:
- LW 0x00001000, ack 3 cycles after req, rdata 0xDEADBEEF:
  - req held 3 cycles with addr 0x00001000, be 1111, we 0;
  - o_done one cycle later, o_rdata 0xDEADBEEF, exc 00.
- LB at 0x00001003, rdata 0x80112233: o_rdata 0xFFFFFF80. LBU at the same address: o_rdata 0x00000080.
- SH at 0x00002002, wdata 0x0000ABCD:
  - o_mem_addr 0x00002000, be 1100, wdata 0xABCDABCD, we 1;
  - on completion o_rdata 0.
- LW at 0x00001002: o_mem_req never rises; o_done the cycle after acceptance with exc 01. Op 4'b0010: exc 11.
- TIMEOUT=4, no ack: req high exactly 4 cycles, then o_done with exc 10, then o_ready=1.
- Reset asserted in the 2nd ACCESS cycle: next cycle req=0, o_ready=1, all outputs 0; a late ack is ignored, no o_done.
